// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution layer tile scheduler.
//   - sched_state_e : scheduler FSM states
//   - num_tiles()   : tiles along one dimension
//   - Default*Tiles : tile counts for the default layer geometry
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        DONE
    } sched_state_e;

    function automatic int unsigned num_tiles(input int unsigned dim, input int unsigned tile);
        return dim / tile;
    endfunction

    localparam int unsigned DefaultRowTiles  = num_tiles(64, 64);
    localparam int unsigned DefaultColTiles  = num_tiles(32, 16);
    localparam int unsigned DefaultNTiles    = num_tiles(32, 16);
    localparam int unsigned DefaultMTiles    = num_tiles(32, 16);
    localparam int unsigned DefaultTotalTiles =
        DefaultRowTiles * DefaultColTiles * DefaultNTiles * DefaultMTiles;

endpackage

// File: rtl/tile_loop_counter.sv
// One tile-loop dimension: holds the tile base and steps it by STEP.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   inc      : advance the base by STEP (wraps to 0 at LIMIT)
//   clr      : force the base to 0
//   wrap     : the next step from the current base would reach LIMIT
//   base     : registered tile base
module tile_loop_counter #(
    parameter int unsigned CW    = 16,
    parameter int unsigned STEP  = 16,
    parameter int unsigned LIMIT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic          wrap,
    output logic [CW-1:0] base
);

    // One extra bit so base + STEP == LIMIT never aliases when LIMIT == 2**CW.
    logic [CW:0] next_sum;

    assign next_sum = {1'b0, base} + (CW + 1)'(STEP);
    assign wrap     = (next_sum == (CW + 1)'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            base <= '0;
        end else if (inc) begin
            base <= wrap ? '0 : next_sum[CW-1:0];
        end
    end

endmodule

// File: rtl/conv_layer_tile_scheduler.sv
// Layer-level controller for the convolution tile engine. Walks the tile loops
// (row, col, n, m; m innermost), issues one conv_tile_start per tile, waits for
// conv_tile_done, leaves START_GAP idle cycles, and pulses layer_done at the end.
// Optional feature macro: CONV_SCHED_PERF_CNT_EN adds the layer_cycles counter.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   layer_start         : start one layer (sampled only in IDLE)
//   layer_done          : one-cycle pulse after the last tile completes
//   busy                : high from first tile issue through last tile done
//   conv_tile_start     : one-cycle tile launch pulse
//   conv_tile_done      : tile completion pulse (honoured only in WAIT)
//   tile_base_*         : registered tile origin
//   tile_index          : ordinal of the current tile
//   layer_cycles        : busy-cycle count (macro builds only)
module conv_layer_tile_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned CW        = 16,
    parameter int unsigned N         = 32,
    parameter int unsigned M         = 32,
    parameter int unsigned R         = 64,
    parameter int unsigned C         = 32,
    parameter int unsigned Tn        = 16,
    parameter int unsigned Tm        = 16,
    parameter int unsigned Tr        = 64,
    parameter int unsigned Tc        = 16,
    parameter int unsigned START_GAP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          layer_start,
    output logic          layer_done,
    output logic          busy,
    output logic          conv_tile_start,
    input  logic          conv_tile_done,
    output logic [CW-1:0] tile_base_n,
    output logic [CW-1:0] tile_base_m,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic [CW-1:0] tile_index
`ifdef CONV_SCHED_PERF_CNT_EN
   ,output logic [31:0]   layer_cycles
`endif
);

    localparam int unsigned TotalTiles =
        num_tiles(R, Tr) * num_tiles(C, Tc) * num_tiles(N, Tn) * num_tiles(M, Tm);

    if ((N % Tn) != 0 || (M % Tm) != 0 || (R % Tr) != 0 || (C % Tc) != 0) begin : g_bad_tiling
        $error("conv_layer_tile_scheduler: every dimension must divide by its tile size");
    end
    if (START_GAP < 1 || START_GAP > 255) begin : g_bad_gap
        $error("conv_layer_tile_scheduler: START_GAP must be 1..255");
    end
    if (CW < 32 && TotalTiles > (32'd1 << CW)) begin : g_bad_cw
        $error("conv_layer_tile_scheduler: tile_index does not fit in CW bits");
    end

    sched_state_e state;
    logic [7:0]   gap_cnt;
    logic         wrap_m, wrap_n, wrap_col, wrap_row;
    logic         last_tile, advance, clr_bases;

    // The last tile is the one where every loop is at its final position.
    assign last_tile = wrap_m & wrap_n & wrap_col & wrap_row;
    assign advance   = (state == WAIT) && conv_tile_done && !last_tile;
    assign clr_bases = (state == DONE);

    tile_loop_counter #(.CW(CW), .STEP(Tm), .LIMIT(M)) u_cnt_m (
        .clk  (clk),
        .rst  (rst),
        .inc  (advance),
        .clr  (clr_bases),
        .wrap (wrap_m),
        .base (tile_base_m)
    );

    tile_loop_counter #(.CW(CW), .STEP(Tn), .LIMIT(N)) u_cnt_n (
        .clk  (clk),
        .rst  (rst),
        .inc  (advance && wrap_m),
        .clr  (clr_bases),
        .wrap (wrap_n),
        .base (tile_base_n)
    );

    tile_loop_counter #(.CW(CW), .STEP(Tc), .LIMIT(C)) u_cnt_col (
        .clk  (clk),
        .rst  (rst),
        .inc  (advance && wrap_m && wrap_n),
        .clr  (clr_bases),
        .wrap (wrap_col),
        .base (tile_base_col)
    );

    tile_loop_counter #(.CW(CW), .STEP(Tr), .LIMIT(R)) u_cnt_row (
        .clk  (clk),
        .rst  (rst),
        .inc  (advance && wrap_m && wrap_n && wrap_col),
        .clr  (clr_bases),
        .wrap (wrap_row),
        .base (tile_base_row)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            busy            <= 1'b0;
            layer_done      <= 1'b0;
            conv_tile_start <= 1'b0;
            tile_index      <= '0;
`ifdef CONV_SCHED_PERF_CNT_EN
            layer_cycles    <= '0;
`endif
        end else begin
            conv_tile_start <= 1'b0;
            layer_done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (layer_start) begin
                        state           <= ISSUE;
                        conv_tile_start <= 1'b1;
                        busy            <= 1'b1;
`ifdef CONV_SCHED_PERF_CNT_EN
                        layer_cycles    <= '0;
`endif
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (conv_tile_done) begin
                        if (last_tile) begin
                            state      <= DONE;
                            layer_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state      <= GAP;
                            tile_index <= tile_index + CW'(1);
                            gap_cnt    <= 8'(START_GAP - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state           <= ISSUE;
                        conv_tile_start <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    tile_index <= '0;
                end
                default: state <= IDLE;
            endcase
`ifdef CONV_SCHED_PERF_CNT_EN
            // busy is low in IDLE, so this never collides with the clear above.
            if (busy && layer_cycles != 32'hFFFF_FFFF) begin
                layer_cycles <= layer_cycles + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_conv_layer_tile_scheduler.sv
// Self-checking bench for conv_layer_tile_scheduler: a default instance driven by a
// tile-engine model with a tile scoreboard, plus a START_GAP=1 instance for
// minimum-spacing and back-to-back layers.
module tb_conv_layer_tile_scheduler;

    localparam int CW = 16;

    typedef struct {
        int          lat;
        logic [15:0] n;
        logic [15:0] m;
        logic [15:0] row;
        logic [15:0] col;
        int          start_off;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, layer_start, conv_tile_done;
    logic          layer_done, busy, conv_tile_start;
    logic [CW-1:0] tile_base_n, tile_base_m, tile_base_row, tile_base_col, tile_index;
    logic          ls1, done1;
    logic          layer_done1, busy1, start1;
    logic [CW-1:0] bn1, bm1, br1, bc1, idx1;
`ifdef CONV_SCHED_PERF_CNT_EN
    logic [31:0]   layer_cycles, layer_cycles1;
`endif

    conv_layer_tile_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .layer_start     (layer_start),
        .layer_done      (layer_done),
        .busy            (busy),
        .conv_tile_start (conv_tile_start),
        .conv_tile_done  (conv_tile_done),
        .tile_base_n     (tile_base_n),
        .tile_base_m     (tile_base_m),
        .tile_base_row   (tile_base_row),
        .tile_base_col   (tile_base_col),
        .tile_index      (tile_index)
`ifdef CONV_SCHED_PERF_CNT_EN
       ,.layer_cycles    (layer_cycles)
`endif
    );

    conv_layer_tile_scheduler #(.START_GAP(1)) dut_g1 (
        .clk             (clk),
        .rst             (rst),
        .layer_start     (ls1),
        .layer_done      (layer_done1),
        .busy            (busy1),
        .conv_tile_start (start1),
        .conv_tile_done  (done1),
        .tile_base_n     (bn1),
        .tile_base_m     (bm1),
        .tile_base_row   (br1),
        .tile_base_col   (bc1),
        .tile_index      (idx1)
`ifdef CONV_SCHED_PERF_CNT_EN
       ,.layer_cycles    (layer_cycles1)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    vec_t tbl[8];
    vec_t sb_q[$];

    // Default-instance engine model state.
    int   nstart0, s0, lat0, last_done0, ld0, ld_off0, base0;
    bit   pend0;
    logic busy_at_ld0;
    int   obs_off[8];

    // START_GAP=1 instance model state.
    int   n1, n1l, s1, last_done1, ld1cnt;
    bit   pend1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle, sample outputs 1 time unit after the edge, then drive
    // the engine models' inputs for the new cycle.
    task automatic tick();
        vec_t e;
        @(posedge clk);
        #1;
        cyc++;
        layer_start = 1'b0;
        ls1         = 1'b0;

        if (conv_tile_start) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_start", 64'd1, 64'd0);
                lat0 = 10;
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("tile_base_%0d", nstart0),
                    {tile_base_n, tile_base_m, tile_base_row, tile_base_col},
                    {e.n, e.m, e.row, e.col});
                chk($sformatf("tile_index_%0d", nstart0), 64'(tile_index), 64'(nstart0));
                lat0 = e.lat;
            end
            if (nstart0 < 8) obs_off[nstart0] = cyc - base0;
            nstart0++;
            s0    = cyc;
            pend0 = 1'b1;
        end
        conv_tile_done = 1'b0;
        if (pend0 && cyc == s0 + lat0) begin
            conv_tile_done = 1'b1;
            pend0          = 1'b0;
            last_done0     = cyc;
        end
        if (layer_done) begin
            ld0++;
            ld_off0     = cyc - base0;
            busy_at_ld0 = busy;
        end

        if (start1) begin
            if (n1l > 0) chk("g1_spacing", 64'(cyc - s1), 64'd3);
            n1l++;
            n1++;
            s1    = cyc;
            pend1 = 1'b1;
        end
        done1 = 1'b0;
        if (pend1 && cyc == s1 + 1) begin
            done1      = 1'b1;
            pend1      = 1'b0;
            last_done1 = cyc;
        end
        if (layer_done1) begin
            ld1cnt++;
            chk("g1_done_lat", 64'(cyc - last_done1), 64'd1);
            chk("g1_busy_at_done", 64'(busy1), 64'd0);
            n1l = 0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_layer_done"}, 64'(layer_done), 64'd0);
        chk({tag, "_tile_start"}, 64'(conv_tile_start), 64'd0);
        chk({tag, "_bases"}, {tile_base_n, tile_base_m, tile_base_row, tile_base_col}, 64'd0);
        chk({tag, "_tile_index"}, 64'(tile_index), 64'd0);
`ifdef CONV_SCHED_PERF_CNT_EN
        chk({tag, "_layer_cycles"}, 64'(layer_cycles), 64'd0);
`endif
    endtask

    // mode 0: plain layer; 1: layer_start during WAIT of tile 3;
    // 2: conv_tile_done during GAP after tile 1; 3: rst during WAIT of tile 5.
    task automatic run_layer(input int mode);
        bit fin;
        nstart0 = 0;
        ld0     = 0;
        pend0   = 1'b0;
        for (int i = 0; i < 8; i++) obs_off[i] = -1;
        for (int i = 0; i < 8; i++) sb_q.push_back(tbl[i]);
        base0       = cyc;
        layer_start = 1'b1;
        fin         = 1'b0;
        for (int t = 0; t < 400 && !fin; t++) begin
            tick();
            if (t == 0) chk("busy_rise", 64'(busy), 64'd1);
            if (mode == 1 && nstart0 == 4 && cyc == s0 + 3) layer_start = 1'b1;
            if (mode == 2 && nstart0 == 2 && !pend0 && cyc == last_done0 + 1)
                conv_tile_done = 1'b1;
            if (mode == 3 && nstart0 == 6 && cyc == s0 + 4) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk_all_zero("abort");
                pend0          = 1'b0;
                conv_tile_done = 1'b0;
                sb_q.delete();
                fin = 1'b1;
            end
            if (ld0 > 0) fin = 1'b1;
        end
        if (!fin) chk("layer_timeout", 64'd0, 64'd1);
    endtask

    task automatic post_layer_checks(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_start_off_%0d", tag, i), 64'(obs_off[i]), 64'(tbl[i].start_off));
        chk({tag, "_num_starts"}, 64'(nstart0), 64'd8);
        chk({tag, "_num_layer_done"}, 64'(ld0), 64'd1);
        chk({tag, "_layer_done_off"}, 64'(ld_off0), 64'd103);
        chk({tag, "_busy_at_done"}, 64'(busy_at_ld0), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        for (int i = 0; i < 10; i++) tick();
        chk({tag, "_no_extra_start"}, 64'(nstart0), 64'd8);
        chk({tag, "_no_extra_done"}, 64'(ld0), 64'd1);
        chk({tag, "_idle_bases"}, {tile_base_n, tile_base_m, tile_base_row, tile_base_col},
            64'd0);
    endtask

    initial begin
        tbl[0] = '{10, 16'd0,  16'd0,  16'd0, 16'd0,  1};
        tbl[1] = '{10, 16'd0,  16'd16, 16'd0, 16'd0,  14};
        tbl[2] = '{10, 16'd16, 16'd0,  16'd0, 16'd0,  27};
        tbl[3] = '{10, 16'd16, 16'd16, 16'd0, 16'd0,  40};
        tbl[4] = '{10, 16'd0,  16'd0,  16'd0, 16'd16, 53};
        tbl[5] = '{10, 16'd0,  16'd16, 16'd0, 16'd16, 66};
        tbl[6] = '{10, 16'd16, 16'd0,  16'd0, 16'd16, 79};
        tbl[7] = '{10, 16'd16, 16'd16, 16'd0, 16'd16, 92};

        rst = 1'b1; layer_start = 1'b0; conv_tile_done = 1'b0; ls1 = 1'b0; done1 = 1'b0;
        nstart0 = 0; s0 = 0; lat0 = 10; last_done0 = 0; ld0 = 0; ld_off0 = 0; base0 = 0;
        pend0 = 1'b0; busy_at_ld0 = 1'b0;
        n1 = 0; n1l = 0; s1 = 0; last_done1 = 0; ld1cnt = 0; pend1 = 1'b0;

        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // conv_tile_done while IDLE must be ignored.
        conv_tile_done = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_done_no_start", 64'(nstart0), 64'd0);
        chk("idle_done_busy", 64'(busy), 64'd0);

        run_layer(0);
`ifdef CONV_SCHED_PERF_CNT_EN
        chk("layer_cycles", 64'(layer_cycles), 64'd102);
`endif
        post_layer_checks("plain");

        run_layer(1);
        post_layer_checks("start_in_wait");

        run_layer(2);
        post_layer_checks("done_in_gap");

        run_layer(3);
        for (int i = 0; i < 20; i++) tick();
        chk("abort_no_layer_done", 64'(ld0), 64'd0);
        chk("abort_no_restart", 64'(nstart0), 64'd6);

        run_layer(0);
        post_layer_checks("after_abort");

        // START_GAP=1, L=1: starts 3 apart, second layer accepted at d+2.
        ls1 = 1'b1;
        for (int t = 0; t < 200 && ld1cnt < 1; t++) tick();
        chk("g1_first_layer_done", 64'(ld1cnt), 64'd1);
        chk("g1_first_layer_starts", 64'(n1), 64'd8);
        tick();
        ls1 = 1'b1;
        tick();
        chk("g1_b2b_start", 64'(start1), 64'd1);
        chk("g1_b2b_bases", {bn1, bm1, br1, bc1}, 64'd0);
        chk("g1_b2b_index", 64'(idx1), 64'd0);
        for (int t = 0; t < 200 && ld1cnt < 2; t++) tick();
        chk("g1_second_layer_done", 64'(ld1cnt), 64'd2);
        chk("g1_total_starts", 64'(n1), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
